// File: rtl/wave_period_meter_pkg.sv
// Shared types and threshold helpers for the waveform period/amplitude meter.
package wave_period_meter_pkg;

    typedef enum logic [1:0] {
        ST_ARM     = 2'd0,
        ST_SYNC    = 2'd1,
        ST_MEASURE = 2'd2
    } state_t;

    localparam logic [9:0] MID_DEFAULT  = 10'h1FF;
    localparam int         HYST_DEFAULT = 16;

    function automatic int thr_lo(input int mid, input int hyst);
        return mid - hyst;
    endfunction

    function automatic int thr_hi(input int mid, input int hyst);
        return mid + hyst;
    endfunction

endpackage

// File: rtl/wave_crossing_det.sv
// Hysteresis comparator: flags valid low samples and rising crossings (combinational, same cycle).
// low_armed is the only state; clear drops it and suppresses the rise flag.
module wave_crossing_det #(
    parameter int                 DATA_W = 10,
    parameter logic [DATA_W-1:0]  LO     = 10'h1EF,
    parameter logic [DATA_W-1:0]  HI     = 10'h20F
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    output logic              low_seen,
    output logic              rise
);

    logic low_armed;

    always_comb begin
        low_seen = sample_valid && !clear && (sample_in <= LO);
        rise     = sample_valid && !clear && low_armed && (sample_in >= HI);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            low_armed <= 1'b0;
        end else if (clear) begin
            low_armed <= 1'b0;
        end else if (rise) begin
            low_armed <= 1'b0;
        end else if (low_seen) begin
            low_armed <= 1'b1;
        end
    end

endmodule

// File: rtl/wave_period_meter.sv
// Averages 2^AVG_LOG2 waveform periods (in valid samples) and reports peak-to-peak amplitude.
// Results one cycle after the completing crossing; accepts one sample per clock, no backpressure.
module wave_period_meter
    import wave_period_meter_pkg::*;
#(
    parameter int                DATA_W   = 10,
    parameter logic [DATA_W-1:0] MID      = DATA_W'(MID_DEFAULT),
    parameter int                HYST     = HYST_DEFAULT,
    parameter int                CNT_W    = 20,
    parameter int                AVG_LOG2 = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    input  logic              clear,
    output logic [CNT_W-1:0]  period_out,
    output logic [DATA_W-1:0] amp_pp_out,
    output logic              result_valid,
    output logic              locked,
    output logic              timeout
);

    localparam int                SUM_W   = CNT_W + AVG_LOG2;
    localparam logic [DATA_W-1:0] LO      = DATA_W'(thr_lo(int'(MID), HYST));
    localparam logic [DATA_W-1:0] HI      = DATA_W'(thr_hi(int'(MID), HYST));
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [SUM_W-1:0]    sum_q, sum_tot;
    logic [AVG_LOG2-1:0] idx_q;
    logic [DATA_W-1:0]   min_q, max_q, min_nx, max_nx;
    logic                low_seen, rise, wrap, sat;

    wave_crossing_det #(
        .DATA_W (DATA_W),
        .LO     (LO),
        .HI     (HI)
    ) u_cross (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (clear),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .low_seen     (low_seen),
        .rise         (rise)
    );

    always_comb begin
        sum_tot = sum_q + SUM_W'(cnt_q);
        min_nx  = (sample_in < min_q) ? sample_in : min_q;
        max_nx  = (sample_in > max_q) ? sample_in : max_q;
        wrap    = (state_q == ST_MEASURE) && rise && (idx_q == '1);
        // Counter would step onto its ceiling with this sample.
        sat     = (state_q == ST_MEASURE) && sample_valid && !clear && !rise
                  && (cnt_q == CNT_MAX - 1'b1);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ARM:     if (low_seen) state_d = ST_SYNC;
            ST_SYNC:    if (rise)     state_d = ST_MEASURE;
            ST_MEASURE: if (sat)      state_d = ST_ARM;
            default:                  state_d = ST_ARM;
        endcase
        if (clear) state_d = ST_ARM;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_ARM;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            sum_q        <= '0;
            idx_q        <= '0;
            min_q        <= '0;
            max_q        <= '0;
            period_out   <= '0;
            amp_pp_out   <= '0;
            result_valid <= 1'b0;
            locked       <= 1'b0;
            timeout      <= 1'b0;
        end else if (clear) begin
            cnt_q        <= '0;
            sum_q        <= '0;
            idx_q        <= '0;
            min_q        <= '0;
            max_q        <= '0;
            result_valid <= 1'b0;
            locked       <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            timeout      <= 1'b0;
            if (state_q == ST_SYNC && rise) begin
                cnt_q <= CNT_W'(1);
                sum_q <= '0;
                idx_q <= '0;
                min_q <= sample_in;
                max_q <= sample_in;
            end else if (state_q == ST_MEASURE && sample_valid) begin
                if (rise) begin
                    cnt_q <= CNT_W'(1);
                    idx_q <= idx_q + 1'b1;
                    if (wrap) begin
                        // Crossing sample opens the next window, so it is excluded from this amplitude.
                        period_out   <= CNT_W'(sum_tot >> AVG_LOG2);
                        amp_pp_out   <= max_q - min_q;
                        result_valid <= 1'b1;
                        locked       <= 1'b1;
                        sum_q        <= '0;
                        min_q        <= sample_in;
                        max_q        <= sample_in;
                    end else begin
                        sum_q <= sum_tot;
                        min_q <= min_nx;
                        max_q <= max_nx;
                    end
                end else begin
                    if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
                    min_q <= min_nx;
                    max_q <= max_nx;
                    if (sat) begin
                        timeout <= 1'b1;
                        locked  <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_wave_period_meter.sv
// Directed bench for wave_period_meter: a default instance plus a CNT_W=8 instance for timeout.
module tb_wave_period_meter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  sample_in = '0;
    logic        sample_valid = 1'b0;
    logic        clear = 1'b0;

    logic [19:0] period_out;
    logic [9:0]  amp_pp_out;
    logic        result_valid, locked, timeout;
    logic [7:0]  p2;
    logic [9:0]  a2;
    logic        rv2, lk2, to2;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int rv_count = 0;
    int to_count = 0;
    int first_cyc = 0;
    int prev_cyc = 0;
    int last_cyc = 0;

    wave_period_meter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .clear        (clear),
        .period_out   (period_out),
        .amp_pp_out   (amp_pp_out),
        .result_valid (result_valid),
        .locked       (locked),
        .timeout      (timeout)
    );

    wave_period_meter #(.CNT_W(8)) dut8 (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .clear        (clear),
        .period_out   (p2),
        .amp_pp_out   (a2),
        .result_valid (rv2),
        .locked       (lk2),
        .timeout      (to2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (result_valid) begin
            if (rv_count == 0) first_cyc = cyc;
            prev_cyc = last_cyc;
            last_cyc = cyc;
            rv_count = rv_count + 1;
        end
        if (timeout) to_count = to_count + 1;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic step(input logic [9:0] v, input logic vld);
        sample_in    = v;
        sample_valid = vld;
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step(10'h000, 1'b1);
        clear = 1'b0;
    endtask

    // Starts with the high half; gap inserts invalid opposite-level samples after each valid one.
    task automatic square(input int cycles, input int gap, input bit noise);
        logic [9:0] v;
        for (int c = 0; c < cycles; c++) begin
            for (int h = 0; h < 2; h++) begin
                for (int i = 0; i < 64; i++) begin
                    v = (h == 0) ? 10'h3FE : 10'h000;
                    if (noise && i < 8) v = i[0] ? 10'h205 : 10'h1F8;
                    step(v, 1'b1);
                    for (int g = 0; g < gap; g++) step((h == 0) ? 10'h000 : 10'h3FE, 1'b0);
                end
            end
        end
    endtask

    initial begin
        int c0;
        int n;
        int per[4];
        per[0] = 100; per[1] = 101; per[2] = 101; per[3] = 102;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_period", period_out, 0);
        check("rst_amp", amp_pp_out, 0);
        check("rst_rv", result_valid, 0);
        check("rst_locked", locked, 0);
        check("rst_timeout", timeout, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Square, 128-sample period
        rv_count = 0;
        c0 = cyc;
        square(10, 0, 1'b0);
        check("sq_count", rv_count, 2);
        check("sq_first_lat", first_cyc - c0, 641);
        check("sq_spacing", last_cyc - prev_cyc, 512);
        check("sq_period", period_out, 128);
        check("sq_amp", amp_pp_out, 10'h3FE);
        check("sq_locked", locked, 1);

        // Period jitter 100,101,101,102 with 0x300/0x080 levels
        do_clear();
        rv_count = 0;
        for (int i = 0; i < 70; i++) step(10'h080, 1'b1);
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < per[p] / 2; i++) step(10'h300, 1'b1);
            for (int i = 0; i < per[p] - per[p] / 2; i++) step(10'h080, 1'b1);
        end
        check("jit_count_before", rv_count, 0);
        step(10'h300, 1'b1);
        check("jit_rv_pulse", result_valid, 1);
        check("jit_period", period_out, 101);
        check("jit_amp", amp_pp_out, 10'h280);
        step(10'h300, 1'b1);
        check("jit_rv_one_cycle", result_valid, 0);

        // clear mid-window: no partial result, outputs hold
        do_clear();
        rv_count = 0;
        square(3, 0, 1'b0);
        for (int i = 0; i < 64; i++) step(10'h3FE, 1'b1);
        clear = 1'b1;
        step(10'h000, 1'b1);
        clear = 1'b0;
        check("clr_locked", locked, 0);
        check("clr_period_hold", period_out, 101);
        check("clr_amp_hold", amp_pp_out, 10'h280);
        check("clr_no_result", rv_count, 0);
        c0 = cyc;
        square(10, 0, 1'b0);
        check("clr_count", rv_count, 2);
        check("clr_first_lat", first_cyc - c0, 641);
        check("clr_period", period_out, 128);

        // Gapped valid: every third cycle
        do_clear();
        rv_count = 0;
        c0 = cyc;
        square(10, 2, 1'b0);
        check("gap_count", rv_count, 2);
        check("gap_first_lat", first_cyc - c0, 1921);
        check("gap_spacing", last_cyc - prev_cyc, 1536);
        check("gap_period", period_out, 128);
        check("gap_amp", amp_pp_out, 10'h3FE);

        // Hysteresis noise inside the dead band
        do_clear();
        rv_count = 0;
        square(10, 0, 1'b1);
        check("hys_count", rv_count, 2);
        check("hys_spacing", last_cyc - prev_cyc, 512);
        check("hys_period", period_out, 128);

        // Timeout on the 8-bit counter instance
        do_clear();
        rv_count = 0;
        to_count = 0;
        square(6, 0, 1'b0);
        check("to_locked_before", lk2, 1);
        check("to_period_before", p2, 128);
        n = 0;
        while (n < 400) begin
            step(10'h3FE, 1'b1);
            n = n + 1;
            if (to2) break;
        end
        check("to_samples", n, 255);
        check("to_locked_after", lk2, 0);
        check("to_period_hold", p2, 128);
        check("to_amp_hold", a2, 10'h3FE);
        step(10'h3FE, 1'b1);
        check("to_pulse_one_cycle", to2, 0);
        check("to_wide_no_timeout", to_count, 0);
        check("to_wide_locked", locked, 1);

        // Reset mid-window
        do_clear();
        square(6, 0, 1'b0);
        check("rstm_locked_before", locked, 1);
        square(2, 0, 1'b0);
        for (int i = 0; i < 32; i++) step(10'h3FE, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstm_period", period_out, 0);
        check("rstm_amp", amp_pp_out, 0);
        check("rstm_locked", locked, 0);
        check("rstm_rv", result_valid, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rv_count = 0;
        c0 = cyc;
        square(10, 0, 1'b0);
        check("rstm_count", rv_count, 2);
        check("rstm_first_lat", first_cyc - c0, 641);
        check("rstm_period_after", period_out, 128);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
